mem_access_stage: RTL

- Pipeline stage directly downstream of the execute stage in the fewcore RV32I pipeline.
- Consumes the execute result (ALU value or effective address), store data, destination register and operation code.
- For loads and stores, runs a request/acknowledge transaction on the data-memory port. Handles byte-lane alignment and sign/zero extension, and stalls execute while a transaction is outstanding.
- Presents a registered writeback bundle (valid, rd, data) to the writeback stage.

---
 rtl/fewcore_pkg.sv | 77 +++++++
 rtl/load_align.sv | 44 ++++
 rtl/mem_access_stage.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fewcore_pkg.sv
// Shared definitions for the fewcore RV32I pipeline: opcode/funct3 constants,
// the memory-stage state enum and store-lane / alignment helper functions.
package fewcore_pkg;

  localparam int XLEN_C = 32;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef struct packed {
    logic [XLEN_C-1:0] wdata;
    logic [3:0]        wstrb;
  } store_lanes_t;

  // Access width from funct3; unsigned variants share the low two bits and
  // every undefined encoding falls back to a full word.
  function automatic size_e access_size(input logic [2:0] f3);
    size_e sz;
    case (f3[1:0])
      2'b00:   sz = SZ_BYTE;
      2'b01:   sz = SZ_HALF;
      default: sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  // Byte enables and replicated write data for a store.
  function automatic store_lanes_t store_lanes(input logic [2:0]        f3,
                                               input logic [1:0]        lsb,
                                               input logic [XLEN_C-1:0] data);
    store_lanes_t l;
    case (access_size(f3))
      SZ_BYTE: begin
        l.wdata = {4{data[7:0]}};
        l.wstrb = 4'b0001 << lsb;
      end
      SZ_HALF: begin
        l.wdata = {2{data[15:0]}};
        l.wstrb = lsb[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        l.wdata = data;
        l.wstrb = 4'b1111;
      end
    endcase
    return l;
  endfunction

  // True when the byte offset does not match the natural alignment.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lsb);
    logic m;
    case (access_size(f3))
      SZ_HALF: m = lsb[0];
      SZ_WORD: m = (lsb != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load-data extraction: selects the addressed byte/half of a memory word and
// sign- or zero-extends it to XLEN. Purely combinational.
module load_align
  import fewcore_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lsb,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and halfword lanes.
  always_comb begin
    case (addr_lsb)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    if (addr_lsb[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Extend the selected lane according to the load flavour.
  always_comb begin
    case (funct3)
      F3_B:    result = {{(XLEN-8){byte_s[7]}}, byte_s};
      F3_BU:   result = {{(XLEN-8){1'b0}}, byte_s};
      F3_H:    result = {{(XLEN-16){half_s[15]}}, half_s};
      F3_HU:   result = {{(XLEN-16){1'b0}}, half_s};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage of the fewcore RV32I pipeline. Pass-through ops write
// back one cycle later; loads/stores run a req/ack transaction on the data
// port while stalling execute. Optional misaligned-access trap is enabled by
// defining MISALIGN_TRAP_EN.
module mem_access_stage
  import fewcore_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADDR_LSB = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [11:0]     operation,
  input  logic [XLEN-1:0] exec_out,
  input  logic [4:0]      address_rd,
  input  logic [XLEN-1:0] content_rs2,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            mem_fault
);

  state_e state_q, state_d;

  logic [6:0]          opcode_s;
  logic [2:0]          funct3_s;
  logic [ADDR_LSB-1:0] lsb_s;
  logic                is_load_s;
  logic                is_store_s;
  logic                is_mem_s;
  logic                accept_s;
  logic                fault_s;
  logic                issue_s;
  store_lanes_t        lanes_s;
  logic [XLEN-1:0]     load_data_s;
  logic                unused_s;

  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [XLEN-1:0]     mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_wstrb_q, mem_wstrb_d;
  logic [4:0]          rd_q, rd_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [ADDR_LSB-1:0] lsb_q, lsb_d;
  logic                wb_valid_q, wb_valid_d;
  logic [4:0]          wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]     wb_data_q, wb_data_d;

  assign opcode_s   = operation[6:0];
  assign funct3_s   = operation[9:7];
  assign lsb_s      = exec_out[ADDR_LSB-1:0];
  assign is_load_s  = (opcode_s == OP_LOAD);
  assign is_store_s = (opcode_s == OP_STORE);
  assign is_mem_s   = is_load_s | is_store_s;
  assign accept_s   = in_valid & (state_q == IDLE);
  assign lanes_s    = store_lanes(funct3_s, lsb_s, content_rs2);
  assign unused_s   = ^operation[11:10];

`ifdef MISALIGN_TRAP_EN
  logic fault_q;

  assign fault_s = misaligned(funct3_s, lsb_s);

  // One-cycle fault pulse for a rejected misaligned load/store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= accept_s & is_mem_s & fault_s;
    end
  end

  assign mem_fault = fault_q;
`else
  assign fault_s   = 1'b0;
  assign mem_fault = 1'b0;
`endif

  assign issue_s = accept_s & is_mem_s & ~fault_s;

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata    (mem_rdata),
    .funct3   (funct3_q),
    .addr_lsb (lsb_q),
    .result   (load_data_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: enter BUSY on an issued access, leave on acknowledge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (issue_s) begin
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_d = IDLE;
        end else begin
          state_d = BUSY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next-values: memory request capture/hold and writeback bundle.
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    rd_d        = rd_q;
    funct3_d    = funct3_q;
    lsb_d       = lsb_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    case (state_q)
      IDLE: begin
        if (accept_s && !is_mem_s) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = address_rd;
          wb_data_d  = exec_out;
        end else if (issue_s) begin
          mem_req_d   = 1'b1;
          mem_we_d    = is_store_s;
          mem_addr_d  = {exec_out[XLEN-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
          mem_wdata_d = is_store_s ? lanes_s.wdata : {XLEN{1'b0}};
          mem_wstrb_d = is_store_s ? lanes_s.wstrb : 4'b0000;
          rd_d        = address_rd;
          funct3_d    = funct3_s;
          lsb_d       = lsb_s;
        end else begin
          mem_req_d = 1'b0;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          if (mem_we_q) begin
            wb_rd_d   = 5'd0;
            wb_data_d = {XLEN{1'b0}};
          end else begin
            wb_rd_d   = rd_q;
            wb_data_d = load_data_s;
          end
        end else begin
          mem_req_d = 1'b1;
        end
      end
      default: begin
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Registered memory-port and writeback outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {XLEN{1'b0}};
      mem_wdata_q <= {XLEN{1'b0}};
      mem_wstrb_q <= 4'b0000;
      rd_q        <= 5'd0;
      funct3_q    <= 3'b000;
      lsb_q       <= {ADDR_LSB{1'b0}};
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= {XLEN{1'b0}};
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      rd_q        <= rd_d;
      funct3_q    <= funct3_d;
      lsb_q       <= lsb_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;

endmodule
